// File: rtl/req_issuer.sv
// Request-issue stage for the ssy grant block: buffers a count of pending jobs,
// pulses request while ssy is idle, retires one job per grant and flags missed grants.
module req_issuer #(
    parameter int MAX_PEND = 7,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             idle,
    input  logic             granted,
    output logic             request,
    output logic [7:0]       pending,
    output logic [CNT_W-1:0] grant_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_ARM,
        S_REQ,
        S_WAIT
    } state_t;

    state_t           state_reg;
    logic [7:0]       pending_reg;
    logic [7:0]       pending_next;
    logic [7:0]       timer_reg;
    logic [CNT_W-1:0] grant_cnt_reg;
    logic             request_reg;
    logic             timeout_err_reg;
    logic             accept;
    logic             retire;

    assign job_ready = (pending_reg != 8'(MAX_PEND));
    assign accept    = job_valid && job_ready;
    assign retire    = (state_reg == S_WAIT) && granted;

    // A simultaneous accept and retire cancel out.
    always_comb begin
        pending_next = pending_reg;
        if (accept && !retire) begin
            pending_next = pending_reg + 8'd1;
        end else if (retire && !accept) begin
            pending_next = pending_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_ARM;
            pending_reg     <= 8'd0;
            timer_reg       <= 8'd0;
            grant_cnt_reg   <= '0;
            request_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            pending_reg     <= pending_next;
            request_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            case (state_reg)
                S_ARM: begin
                    if (pending_reg != 8'd0 && idle) begin
                        state_reg   <= S_REQ;
                        request_reg <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_reg <= S_WAIT;
                    timer_reg <= 8'd0;
                end
                S_WAIT: begin
                    if (granted) begin
                        state_reg     <= S_ARM;
                        grant_cnt_reg <= grant_cnt_reg + CNT_W'(1);
                        timer_reg     <= 8'd0;
                    end else if (timer_reg == 8'(TIMEOUT - 1)) begin
                        // Job stays pending so ARM will retry it.
                        state_reg       <= S_ARM;
                        timeout_err_reg <= 1'b1;
                        timer_reg       <= 8'd0;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= S_ARM;
                end
            endcase
        end
    end

    assign request     = request_reg;
    assign pending     = pending_reg;
    assign grant_cnt   = grant_cnt_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_req_issuer.sv
// Scoreboard bench for req_issuer: directed stimulus queues expected request and
// timeout pulses by cycle; a negedge monitor pops and compares them.
module tb_req_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic        idle = 1'b0;
    logic        granted = 1'b0;
    logic        request;
    logic [7:0]  pending;
    logic [15:0] grant_cnt;
    logic        timeout_err;

    req_issuer #(.MAX_PEND(7), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .idle       (idle),
        .granted    (granted),
        .request    (request),
        .pending    (pending),
        .grant_cnt  (grant_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = request pulse, 1 = timeout pulse
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    bit   sb_en = 1'b1;
    logic idle_last = 1'b0;
    int   exp_gcnt = 0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        idle_last <= idle;
    end

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        nchk++;
        if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d expected none",
                     kind == 0 ? "request" : "timeout", cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                nerr++;
                $display("FAIL event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Monitor: scoreboard for pulses plus always-on safety properties.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb_en && request)     pop_cmp(0);
            if (sb_en && timeout_err) pop_cmp(1);
            if (request) check("idle_gate", int'(idle_last), 1);
            nchk++;
            if (pending > 8'd7) begin
                nerr++;
                $display("FAIL pending_max: got %0d expected <= 7", pending);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("rst_request", int'(request), 0);
        check("rst_job_ready", int'(job_ready), 1);
        check("rst_pending", int'(pending), 0);
        check("rst_grant_cnt", int'(grant_cnt), 0);
        check("rst_timeout", int'(timeout_err), 0);
        step();
        reset = 1'b0;
        step();
        check("rel_job_ready", int'(job_ready), 1);
        check("rel_pending", int'(pending), 0);

        // Single job
        idle = 1'b1;
        job_valid = 1'b1;
        c = cyc;
        expect_ev(0, c + 2);
        step();
        job_valid = 1'b0;
        check("single_pend1", int'(pending), 1);
        step();
        step();
        check("single_pend_wait", int'(pending), 1);
        granted = 1'b1;
        step();
        granted = 1'b0;
        exp_gcnt = 1;
        check("single_pend0", int'(pending), 0);
        check("single_gcnt", int'(grant_cnt), exp_gcnt);
        step();

        // Fill to saturation with ssy busy
        idle = 1'b0;
        job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("full_pend", int'(pending), (i + 1 > 7) ? 7 : i + 1);
        end
        job_valid = 1'b0;
        check("full_ready", int'(job_ready), 0);

        // Drain with one grant per WAIT
        idle = 1'b1;
        for (int i = 0; i < 7; i++) begin
            expect_ev(0, cyc + 1);
            step();
            step();
            granted = 1'b1;
            step();
            granted = 1'b0;
            exp_gcnt++;
            check("drain_pend", int'(pending), 6 - i);
            check("drain_gcnt", int'(grant_cnt), exp_gcnt);
        end
        check("drain_ready", int'(job_ready), 1);
        step();

        // Timeout and retry
        job_valid = 1'b1;
        c = cyc;
        expect_ev(0, c + 2);
        expect_ev(1, c + 19);
        expect_ev(0, c + 20);
        step();
        job_valid = 1'b0;
        repeat (18) step();
        check("tmo_pend", int'(pending), 1);
        check("tmo_gcnt", int'(grant_cnt), exp_gcnt);
        step();
        step();
        granted = 1'b1;
        step();
        granted = 1'b0;
        exp_gcnt++;
        check("retry_pend", int'(pending), 0);
        check("retry_gcnt", int'(grant_cnt), exp_gcnt);

        // Simultaneous accept and grant with three pending
        idle = 1'b0;
        job_valid = 1'b1;
        repeat (3) step();
        job_valid = 1'b0;
        check("sim_pend_pre", int'(pending), 3);
        idle = 1'b1;
        expect_ev(0, cyc + 1);
        step();
        step();
        job_valid = 1'b1;
        granted = 1'b1;
        step();
        job_valid = 1'b0;
        granted = 1'b0;
        idle = 1'b0;
        exp_gcnt++;
        check("sim_pend", int'(pending), 3);
        check("sim_gcnt", int'(grant_cnt), exp_gcnt);
        step();

        // Random idle / job_valid / granted; gating checked by the monitor
        sb_en = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            idle      = 1'($urandom_range(0, 1));
            job_valid = 1'($urandom_range(0, 1));
            granted   = ($urandom_range(0, 3) == 0);
            step();
        end

        // Reset mid-WAIT
        granted = 1'b0;
        idle = 1'b1;
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        for (int i = 0; i < 40 && !request; i++) step();
        check("reach_req", int'(request), 1);
        step();
        #2 reset = 1'b1;
        #1;
        check("mid_pending", int'(pending), 0);
        check("mid_request", int'(request), 0);
        check("mid_gcnt", int'(grant_cnt), 0);
        check("mid_timeout", int'(timeout_err), 0);
        check("mid_ready", int'(job_ready), 1);
        step();
        reset = 1'b0;
        sb_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_request", int'(request), 0);
        end
        check("post_rst_pending", int'(pending), 0);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/req_issuer.md
# req_issuer

Upstream request-issue stage for the `ssy` grant block. It accepts jobs from a producer with a valid/ready handshake and holds them as a pending count. It drives `ssy.request` as a one-cycle pulse, only while `ssy` reports `idle`. It then waits for `granted`, retires one job per grant, and raises a timeout error pulse when a grant never arrives.

## Interface
- `MAX_PEND`, default 7: maximum number of pending jobs (1..255).
- `TIMEOUT`, default 16: number of cycles spent in WAIT without `granted` before a timeout (2..255).
- `CNT_W`, default 16: width of the grant counter.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `job_valid` in 1: producer offers one job.
- `job_ready` out 1: block can accept a job.
- `idle` in 1: from `ssy`; the grant block is ready for a request.
- `granted` in 1: from `ssy`; the outstanding request was granted.
- `request` out 1: to `ssy`; registered one-cycle request pulse.
- `pending` out 8: number of jobs accepted but not yet granted.
- `grant_cnt` out CNT_W: total grants, wraps modulo 2^CNT_W.
- `timeout_err` out 1: one-cycle pulse when a WAIT times out.

## Operation
- Accept: a job is accepted when `job_valid && job_ready` at a rising edge.
  - `job_ready = (pending != MAX_PEND)`; this is combinational from registered `pending` only.
- FSM states:
  - **ARM** (reset state):
    - If `pending != 0` and `idle == 1`, go to REQ.
    - Otherwise stay.
  - **REQ**:
    - `request = 1` for exactly this one cycle.
    - Always go to WAIT next.
  - **WAIT**:
    - `request = 0`.
    - If `granted == 1`, go to ARM: `pending` decrements by 1, `grant_cnt` increments by 1, timer clears.
    - Else, if timer == TIMEOUT-1, go to ARM: `timeout_err = 1` next cycle, `pending` unchanged (the job is retried), timer clears.
    - Else the timer increments.
- `granted` is ignored in ARM and REQ: no counter change and no error.
- Accept and grant at the same edge: `pending` is unchanged, and `grant_cnt` still increments.
- ARM re-checks `pending` and `idle` using values after any retire at that edge. Back-to-back requests are therefore at least 3 cycles apart (REQ, WAIT, ARM).
- `request` is only ever asserted when `idle` was 1 at the edge that entered REQ. Whether `idle` has dropped since does not retract the pulse.
- `timeout_err` is a registered pulse, high only in the cycle after the timeout edge.
- Asynchronous reset mid-operation:
  - Immediately forces ARM, `request = 0`, `pending = 0`, timer = 0, `grant_cnt = 0`, `timeout_err = 0`.
  - Any in-flight request is abandoned, and accepted jobs are discarded.

## Timing
- Reset values: `request` 0, `job_ready` 1, `pending` 0, `grant_cnt` 0, `timeout_err` 0.
- Request latency: `pending > 0` and `idle = 1` sampled at edge N gives `request` high from edge N to edge N+1.
- First job latency: job accepted at edge N with `idle` held at 1 gives `request` high after edge N+1.
- Grant: `granted` sampled at edge M while in WAIT gives `pending`/`grant_cnt` updated after M, and a new REQ possible at edge M+1 at the earliest.
- Timeout: WAIT entered at edge W with no `granted` gives `timeout_err` high after edge W+TIMEOUT for one cycle.
- All outputs except `job_ready` are direct register outputs. There is no combinational path from any input to any output.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → all outputs take their reset values immediately. Deassert → `job_ready = 1`, `pending = 0`.
- **Single job:** `idle = 1`, one `job_valid` pulse at edge 1, `granted` driven for one cycle at the first edge after `request` falls → `request` high exactly in cycle 2, `pending` goes 1 then 0, `grant_cnt = 1`.
- **Full:** `idle = 0`, `job_valid` held for 10 cycles → `pending` saturates at 7, `job_ready = 0`, and no `request` is issued. Then `idle = 1` with a grant each WAIT → 7 request pulses, `pending = 0`, `grant_cnt = 7`.
- **Timeout and retry:** one job, `idle = 1`, `granted` held 0 → `timeout_err` pulses exactly 16 cycles after WAIT entry, `pending` stays 1, and a new `request` follows.
- **Simultaneous:** `pending = 3`, `job_valid` and `granted` at the same WAIT edge → `pending = 3`, `grant_cnt` incremented by 1.
- **Idle gating and reset mid-WAIT:** random `idle` and `job_valid` for 2000 cycles → `request` is never high unless `idle` was 1 at the preceding edge, and `pending` never exceeds 7. Assert `reset` during WAIT → `pending = 0`, `request` stays 0.
